// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a sweep requester and decoder_scan_ctrl.
// The requester drives start/abort/cont/dwell. The controller drives the
// decoder code (enc/en_n) and reports sweep status back.
interface decoder_scan_ctrl_if #(
    parameter int N = 3
);
    logic         start;
    logic         abort;
    logic         cont;
    logic [7:0]   dwell;
    logic [N-1:0] enc;
    logic         en_n;
    logic         busy;
    logic         done;
    logic [7:0]   pass_cnt;

    modport master (
        output start, abort, cont, dwell,
        input  enc, en_n, busy, done, pass_cnt
    );

    modport slave (
        input  start, abort, cont, dwell,
        output enc, en_n, busy, done, pass_cnt
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Sweeps a binary code across an N-to-2^N decoder. Each code is enabled for
// max(dwell,1) cycles. Between codes there is a one-cycle blank with en_n high,
// so the decoder output never glitches between two one-hot values.
module decoder_scan_ctrl #(
    parameter int N = 3,
    parameter int M = 2**N
) (
    input  logic                clk,
    input  logic                rst_n,
    decoder_scan_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    localparam logic [N-1:0] LAST_CODE = N'(M - 1);

    state_t       state_q, state_d;
    logic [N-1:0] enc_q, enc_d;
    logic         en_n_q, en_n_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [7:0]   pass_q, pass_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [7:0]   reload_q, reload_d;   // max(dwell,1)-1, captured at start
    logic         cont_q, cont_d;

    logic [7:0]   dwell_ld;
    logic [7:0]   pass_sat;

    // A dwell of 0 behaves like 1, so the reload value never underflows.
    assign dwell_ld = (bus.dwell == 8'd0) ? 8'd0 : bus.dwell - 8'd1;
    assign pass_sat = (pass_q == 8'hFF) ? pass_q : pass_q + 8'd1;

    // Next-state and registered-output decode. Code changes happen only
    // while en_n is being driven high (BLANK or IDLE entry).
    always_comb begin
        state_d  = state_q;
        enc_d    = enc_q;
        en_n_d   = en_n_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        cont_d   = cont_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d  = ACTIVE;
                    enc_d    = '0;
                    en_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    cont_d   = bus.cont;
                    reload_d = dwell_ld;
                    cnt_d    = dwell_ld;
                end
            end
            ACTIVE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    enc_d   = '0;
                    en_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (enc_q != LAST_CODE) begin
                    state_d = BLANK;
                    en_n_d  = 1'b1;
                    enc_d   = enc_q + 1'b1;
                end else if (!cont_q) begin
                    state_d = IDLE;
                    enc_d   = '0;
                    en_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = pass_sat;
                end else begin
                    state_d = BLANK;
                    en_n_d  = 1'b1;
                    enc_d   = '0;
                    pass_d  = pass_sat;
                end
            end
            BLANK: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    enc_d   = '0;
                    en_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ACTIVE;
                    en_n_d  = 1'b0;
                    cnt_d   = reload_q;
                end
            end
            default: begin
                state_d = IDLE;
                enc_d   = '0;
                en_n_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and output registers; reset forces the idle/quiet condition at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            enc_q    <= '0;
            en_n_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 8'd0;
            cnt_q    <= 8'd0;
            reload_q <= 8'd0;
            cont_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            enc_q    <= enc_d;
            en_n_q   <= en_n_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            cont_q   <= cont_d;
        end
    end

    assign bus.enc      = enc_q;
    assign bus.en_n     = en_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass_cnt = pass_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl. Stimulus pushes the hand-derived
// per-cycle output trace of each sweep. The monitor pops one entry on every
// cycle the DUT shows busy or done, and it also checks the decoder
// break-before-make behaviour.
module tb_decoder_scan_ctrl;
    typedef struct packed {
        logic [2:0] enc;
        logic       en_n;
        logic       busy;
        logic       done;
        logic [7:0] pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   busy_total = 0;
    int   done_total = 0;
    exp_t q[$];
    logic [7:0] dec;

    decoder_scan_ctrl_if #(.N(3)) bus ();

    decoder_scan_ctrl #(.N(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference 3-to-8 decoder driven by the controller outputs.
    always_comb begin
        dec = 8'd0;
        if (!bus.en_n) dec[bus.enc] = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int p);
        return (p > 255) ? 255 : p;
    endfunction

    task automatic push(input int e, input bit en, input bit b, input bit d, input int p);
        exp_t x;
        x.enc  = 3'(e);
        x.en_n = en;
        x.busy = b;
        x.done = d;
        x.pass = 8'(sat(p));
        q.push_back(x);
    endtask

    // Codes 0..upto-1 fully (dwell + following blank), then one active cycle of upto.
    task automatic push_partial(input int d, input int upto, input int p);
        for (int c = 0; c < upto; c++) begin
            for (int k = 0; k < d; k++) push(c, 1'b0, 1'b1, 1'b0, p);
            push(c + 1, 1'b1, 1'b1, 1'b0, p);
        end
        push(upto, 1'b0, 1'b1, 1'b0, p);
    endtask

    task automatic push_sweep(input int d, input bit cont, input int p);
        push_partial(d, 7, p);
        for (int k = 1; k < d; k++) push(7, 1'b0, 1'b1, 1'b0, p);
        if (cont) push(0, 1'b1, 1'b1, 1'b0, p + 1);
        else      push(0, 1'b1, 1'b0, 1'b1, p + 1);
    endtask

    task automatic chk_idle(input string name, input int pass);
        chk({name, "_enc"},  int'(bus.enc), 0);
        chk({name, "_en_n"}, int'(bus.en_n), 1);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_done"}, int'(bus.done), 0);
        chk({name, "_pass"}, int'(bus.pass_cnt), pass);
    endtask

    task automatic pulse_start(input int dw, input bit cn);
        bus.dwell = 8'(dw);
        bus.cont  = cn;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles", name, budget);
        end
    endtask

    task automatic wait_code(input string name, input int e, input int p, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!bus.en_n && int'(bus.enc) == e && int'(bus.pass_cnt) == p) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: code %0d never enabled", name, e);
        end
    endtask

    // Monitor: scoreboard pop, decoder one-hot and break-before-make checks.
    initial begin
        exp_t act, e;
        logic [2:0] prev_enc = 3'd0;
        logic       prev_en_n = 1'b1;
        forever begin
            @(negedge clk);
            act = '{bus.enc, bus.en_n, bus.busy, bus.done, bus.pass_cnt};
            if (bus.busy || bus.done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow: got %h with no expected entry", act);
                end else begin
                    e = q.pop_front();
                    if (act != e) begin
                        errors++;
                        $display("FAIL trace: got enc=%0d en_n=%0d busy=%0d done=%0d pass=%0d expected enc=%0d en_n=%0d busy=%0d done=%0d pass=%0d",
                                 act.enc, act.en_n, act.busy, act.done, act.pass,
                                 e.enc, e.en_n, e.busy, e.done, e.pass);
                    end
                end
            end
            if (bus.en_n ? (dec != 8'd0) : ($countones(dec) != 1)) begin
                checks++;
                errors++;
                $display("FAIL decoder_onehot: got dec=%b with en_n=%0d", dec, bus.en_n);
            end
            if (!prev_en_n && !bus.en_n) begin
                checks++;
                if (bus.enc != prev_enc) begin
                    errors++;
                    $display("FAIL break_before_make: got enc %0d->%0d while enabled required no change",
                             prev_enc, bus.enc);
                end
            end
            prev_enc  = bus.enc;
            prev_en_n = bus.en_n;
            busy_total += int'(bus.busy);
            done_total += int'(bus.done);
        end
    end

    initial begin
        int b0, d0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.cont  = 1'b0;
        bus.dwell = 8'd0;
        repeat (2) @(negedge clk);
        chk_idle("reset", 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sweep, dwell=2, with start re-pulsed and inputs changed mid-sweep.
        b0 = busy_total; d0 = done_total;
        push_sweep(2, 1'b0, 0);
        pulse_start(2, 1'b0);
        repeat (9) @(negedge clk);
        pulse_start(5, 1'b1);
        wait_idle("sweep_d2", 60);
        bus.dwell = 8'd0;
        bus.cont  = 1'b0;
        @(negedge clk);
        chk("sweep_d2_busy_cycles", busy_total - b0, 23);
        chk("sweep_d2_done_pulses", done_total - d0, 1);
        chk("sweep_d2_pass", int'(bus.pass_cnt), 1);

        // start and abort together in IDLE: no sweep begins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_idle("start_abort", 1);
        repeat (3) @(negedge clk);
        chk("start_abort_still_idle", int'(bus.busy), 0);

        // dwell=0 behaves as one cycle per code.
        b0 = busy_total; d0 = done_total;
        push_sweep(1, 1'b0, 1);
        pulse_start(0, 1'b0);
        wait_idle("sweep_d0", 40);
        @(negedge clk);
        chk("sweep_d0_busy_cycles", busy_total - b0, 15);
        chk("sweep_d0_done_pulses", done_total - d0, 1);
        chk("sweep_d0_pass", int'(bus.pass_cnt), 2);

        // Continuous dwell=1: three sweeps, then abort while code 4 is enabled.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_total;
        for (int s = 0; s < 3; s++) push_sweep(1, 1'b1, s);
        push_partial(1, 4, 3);
        pulse_start(1, 1'b1);
        wait_code("cont_abort", 4, 3, 100);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_idle("cont_abort", 3);
        chk("cont_abort_no_done", done_total - d0, 0);
        chk("cont_abort_queue_empty", q.size(), 0);

        // Asynchronous reset mid-ACTIVE at code 5, then start on the release edge.
        d0 = done_total;
        push_partial(3, 5, 3);
        pulse_start(3, 1'b0);
        wait_code("async_rst", 5, 3, 60);
        #2 rst_n = 1'b0;
        #1 chk_idle("async_rst", 0);
        chk("async_rst_queue_empty", q.size(), 0);
        @(negedge clk);
        chk("async_rst_no_done", done_total - d0, 0);
        b0 = busy_total; d0 = done_total;
        push_sweep(1, 1'b0, 0);
        rst_n = 1'b1;
        pulse_start(0, 1'b0);
        wait_idle("post_rst", 40);
        @(negedge clk);
        chk("post_rst_busy_cycles", busy_total - b0, 15);
        chk("post_rst_done_pulses", done_total - d0, 1);

        // pass_cnt saturation: 257 continuous sweeps, abort during final wrap blank.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 257; s++) push_sweep(1, 1'b1, s);
        pulse_start(1, 1'b1);
        repeat (257 * 16 - 1) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_idle("saturate", 255);
        chk("saturate_queue_empty", q.size(), 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
